// File: rtl/sha256_block_ctrl_if.sv
// Block-source and digest-consumer handshakes of the SHA-256 block controller.
interface sha256_block_ctrl_if;
    logic blk_valid;
    logic blk_ready;
    logic blk_first;
    logic blk_last;
    logic digest_valid;
    logic digest_ready;

    // Host side: offers blocks and takes the digest.
    modport master (
        output blk_valid, blk_first, blk_last, digest_ready,
        input  blk_ready, digest_valid
    );

    // Controller side.
    modport slave (
        input  blk_valid, blk_first, blk_last, digest_ready,
        output blk_ready, digest_valid
    );
endinterface

// File: rtl/sha256_block_ctrl.sv
// SHA-256 block sequencing controller: accepts a block, pulses the scheduler
// load, runs 64 compression rounds, pulses the hash update and, on the last
// block of a message, holds the digest until it is taken. Carries no data.
module sha256_block_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sha256_block_ctrl_if.slave   bus,
    output logic                 sched_load,
    output logic                 hash_init,
    output logic                 round_en,
    output logic [5:0]           round_idx,
    output logic                 hash_update,
    output logic [CNT_W-1:0]     blk_cnt,
    output logic                 proto_err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUNDS,
        UPDATE,
        DONE
    } state_t;

    state_t state;
    logic   msg_open;
    logic   first_q;
    logic   last_q;
    logic   blk_ready;
    logic   digest_valid;

    assign bus.blk_ready    = blk_ready;
    assign bus.digest_valid = digest_valid;

    // Controller FSM; every output is a register set together with the state
    // it belongs to, so outputs always match the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            msg_open     <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            blk_cnt      <= '0;
            proto_err    <= 1'b0;
            blk_ready    <= 1'b1;
            digest_valid <= 1'b0;
            sched_load   <= 1'b0;
            hash_init    <= 1'b0;
            round_en     <= 1'b0;
            round_idx    <= 6'd0;
            hash_update  <= 1'b0;
        end else begin
            sched_load  <= 1'b0;
            hash_init   <= 1'b0;
            hash_update <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.blk_valid) begin
                        first_q <= bus.blk_first;
                        last_q  <= bus.blk_last;
                        if (!bus.blk_first && !msg_open) begin
                            // Continuation with no open message: drop it and stay ready.
                            proto_err <= 1'b1;
                        end else begin
                            state      <= LOAD;
                            blk_ready  <= 1'b0;
                            sched_load <= 1'b1;
                            hash_init  <= bus.blk_first;
                        end
                    end
                end
                LOAD: begin
                    msg_open <= 1'b1;
                    if (first_q) begin
                        blk_cnt <= CNT_W'(1);
                    end else if (blk_cnt != '1) begin
                        blk_cnt <= blk_cnt + CNT_W'(1);
                    end
                    state     <= ROUNDS;
                    round_en  <= 1'b1;
                    round_idx <= 6'd0;
                end
                ROUNDS: begin
                    if (round_idx == 6'd63) begin
                        state       <= UPDATE;
                        round_en    <= 1'b0;
                        round_idx   <= 6'd0;
                        hash_update <= 1'b1;
                    end else begin
                        round_idx <= round_idx + 6'd1;
                    end
                end
                UPDATE: begin
                    if (last_q) begin
                        msg_open     <= 1'b0;
                        state        <= DONE;
                        digest_valid <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        blk_ready <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.digest_ready) begin
                        state        <= IDLE;
                        digest_valid <= 1'b0;
                        blk_ready    <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    blk_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Directed bench for sha256_block_ctrl: a default-width instance and a
// CNT_W=2 instance run the same stimulus so counter saturation is visible.
module tb_sha256_block_ctrl;

    logic       clk;
    logic       rst_n;
    logic       sched_load8, hash_init8, round_en8, hash_update8, proto_err8;
    logic [5:0] round_idx8;
    logic [7:0] blk_cnt8;
    logic       sched_load2, hash_init2, round_en2, hash_update2, proto_err2;
    logic [5:0] round_idx2;
    logic [1:0] blk_cnt2;

    int vec_cnt = 0;
    int err_cnt = 0;

    sha256_block_ctrl_if bus8 ();
    sha256_block_ctrl_if bus2 ();

    assign bus2.blk_valid    = bus8.blk_valid;
    assign bus2.blk_first    = bus8.blk_first;
    assign bus2.blk_last     = bus8.blk_last;
    assign bus2.digest_ready = bus8.digest_ready;

    sha256_block_ctrl dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus8.slave),
        .sched_load  (sched_load8),
        .hash_init   (hash_init8),
        .round_en    (round_en8),
        .round_idx   (round_idx8),
        .hash_update (hash_update8),
        .blk_cnt     (blk_cnt8),
        .proto_err   (proto_err8)
    );

    sha256_block_ctrl #(.CNT_W(2)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus2.slave),
        .sched_load  (sched_load2),
        .hash_init   (hash_init2),
        .round_en    (round_en2),
        .round_idx   (round_idx2),
        .hash_update (hash_update2),
        .blk_cnt     (blk_cnt2),
        .proto_err   (proto_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one block at the current negedge and follow it through UPDATE,
    // ending at the negedge of cycle N+67.
    task automatic run_block(input logic first, input logic last, input logic exp_init,
                             input int exp_cnt8, input int exp_cnt2);
        bus8.blk_valid = 1'b1;
        bus8.blk_first = first;
        bus8.blk_last  = last;
        check("ready_before_hs", bus8.blk_ready, 1'b1);
        @(negedge clk);
        bus8.blk_valid = 1'b0;
        bus8.blk_first = 1'b0;
        bus8.blk_last  = 1'b0;
        check("sched_load", sched_load8, 1'b1);
        check("hash_init", hash_init8, exp_init);
        check("ready_in_load", bus8.blk_ready, 1'b0);
        check("hash_init_w2", hash_init2, exp_init);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            check("round_en", round_en8, 1'b1);
            check("round_idx", round_idx8, i);
            if (i == 0) begin
                check("sched_load_off", sched_load8, 1'b0);
                check("blk_cnt", blk_cnt8, exp_cnt8);
                check("blk_cnt_w2", blk_cnt2, exp_cnt2);
            end
        end
        @(negedge clk);
        check("hash_update", hash_update8, 1'b1);
        check("round_en_off", round_en8, 1'b0);
        check("round_idx_zero", round_idx8, 0);
        @(negedge clk);
        check("hash_update_off", hash_update8, 1'b0);
        check("digest_valid_end", bus8.digest_valid, last);
        check("ready_end", bus8.blk_ready, !last);
    endtask

    // Take the digest at the current negedge; IDLE follows one cycle later.
    task automatic finish_digest(input int exp_cnt8, input int exp_cnt2);
        check("digest_valid", bus8.digest_valid, 1'b1);
        check("ready_in_done", bus8.blk_ready, 1'b0);
        bus8.digest_ready = 1'b1;
        @(negedge clk);
        bus8.digest_ready = 1'b0;
        check("digest_valid_off", bus8.digest_valid, 1'b0);
        check("ready_after_done", bus8.blk_ready, 1'b1);
        check("blk_cnt_hold", blk_cnt8, exp_cnt8);
        check("blk_cnt_hold_w2", blk_cnt2, exp_cnt2);
    endtask

    initial begin
        rst_n             = 1'b0;
        bus8.blk_valid    = 1'b0;
        bus8.blk_first    = 1'b0;
        bus8.blk_last     = 1'b0;
        bus8.digest_ready = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", bus8.blk_ready, 1'b1);
        check("rst_digest_valid", bus8.digest_valid, 1'b0);
        check("rst_sched_load", sched_load8, 1'b0);
        check("rst_round_en", round_en8, 1'b0);
        check("rst_round_idx", round_idx8, 0);
        check("rst_blk_cnt", blk_cnt8, 0);
        check("rst_proto_err", proto_err8, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-block message
        run_block(1'b1, 1'b1, 1'b1, 1, 1);
        finish_digest(1, 1);

        // Two-block message, second block offered at N+67
        run_block(1'b1, 1'b0, 1'b1, 1, 1);
        run_block(1'b0, 1'b1, 1'b0, 2, 2);

        // Digest held for 10 cycles; a block offered meanwhile is ignored
        bus8.blk_valid = 1'b1;
        bus8.blk_first = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("done_hold_valid", bus8.digest_valid, 1'b1);
            check("done_hold_ready", bus8.blk_ready, 1'b0);
            check("done_no_load", sched_load8, 1'b0);
        end
        bus8.blk_valid = 1'b0;
        bus8.blk_first = 1'b0;
        finish_digest(2, 2);

        // Continuation block with no open message is dropped
        bus8.blk_valid = 1'b1;
        bus8.blk_first = 1'b0;
        bus8.blk_last  = 1'b0;
        @(negedge clk);
        bus8.blk_valid = 1'b0;
        check("err_proto_err", proto_err8, 1'b1);
        check("err_no_load", sched_load8, 1'b0);
        check("err_ready", bus8.blk_ready, 1'b1);
        check("err_blk_cnt", blk_cnt8, 2);
        run_block(1'b1, 1'b1, 1'b1, 1, 1);
        check("err_sticky", proto_err8, 1'b1);
        finish_digest(1, 1);
        check("err_sticky_late", proto_err8, 1'b1);

        // Reset pulse during round 30
        bus8.blk_valid = 1'b1;
        bus8.blk_first = 1'b1;
        bus8.blk_last  = 1'b0;
        @(negedge clk);
        bus8.blk_valid = 1'b0;
        bus8.blk_first = 1'b0;
        for (int i = 0; i < 31; i++) @(negedge clk);
        check("pre_rst_idx", round_idx8, 30);
        rst_n = 1'b0;
        #1;
        check("mid_rst_round_en", round_en8, 1'b0);
        check("mid_rst_round_idx", round_idx8, 0);
        check("mid_rst_ready", bus8.blk_ready, 1'b1);
        check("mid_rst_blk_cnt", blk_cnt8, 0);
        check("mid_rst_proto_err", proto_err8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_block(1'b1, 1'b1, 1'b1, 1, 1);
        finish_digest(1, 1);

        // Five-block message, then restart while it is still open
        run_block(1'b1, 1'b0, 1'b1, 1, 1);
        run_block(1'b0, 1'b0, 1'b0, 2, 2);
        run_block(1'b0, 1'b0, 1'b0, 3, 3);
        run_block(1'b0, 1'b0, 1'b0, 4, 3);
        run_block(1'b0, 1'b0, 1'b0, 5, 3);
        run_block(1'b1, 1'b1, 1'b1, 1, 1);
        check("restart_no_err", proto_err8, 1'b0);
        finish_digest(1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/sha256_block_ctrl.md
# sha256_block_ctrl

Sequencing controller for the SHA-256 datapath. It accepts 512-bit message blocks through a valid/ready handshake and tracks multi-block message boundaries. For each block it drives the message-scheduler load, the 64 compression rounds and the hash-state update, then presents the final digest through a second handshake. It sits between the host-side block source and the message scheduler / compression core; it carries no data itself.

## Interface
- CNT_W, 8: width of the per-message block counter.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- blk_valid  in  1  block source presents a block.
- blk_ready  out  1  controller accepts a block this cycle.
- blk_first  in  1  block is the first block of a message; qualified by blk_valid.
- blk_last  in  1  block is the last block of a message; qualified by blk_valid.
- sched_load  out  1  one-cycle pulse: scheduler captures block_in.
- hash_init  out  1  with sched_load: reset hash state H0..H7 to the IV before this block.
- round_en  out  1  compression round active.
- round_idx  out  6  current round t (0..63); 0 when round_en=0.
- hash_update  out  1  one-cycle pulse: H += working variables a..h.
- digest_valid  out  1  final digest is available on the datapath.
- digest_ready  in  1  consumer takes the digest.
- blk_cnt  out  CNT_W  blocks accepted in the current message, saturating.
- proto_err  out  1  sticky: a continuation block arrived with no open message.

## Operation
- States: IDLE, LOAD, ROUNDS, UPDATE, DONE. All outputs are Moore-decoded from state and registers.
- IDLE:
  - blk_ready=1.
  - On blk_valid&&blk_ready, capture first_q=blk_first and last_q=blk_last.
  - If blk_first=0 and msg_open=0: set proto_err, drop the block, stay in IDLE.
  - Otherwise go to LOAD.
- LOAD (1 cycle):
  - sched_load=1; hash_init=first_q.
  - msg_open<=1.
  - blk_cnt<=1 if first_q, else blk_cnt+1, saturating at 2^CNT_W-1.
- ROUNDS (64 cycles):
  - round_en=1; round_idx counts 0..63.
  - Leave after round_idx=63.
- UPDATE (1 cycle):
  - hash_update=1.
  - If last_q: msg_open<=0 and go to DONE; otherwise go to IDLE.
- DONE:
  - digest_valid=1, held until digest_ready=1 in the same cycle.
  - blk_ready=0 throughout.
  - Then go to IDLE. blk_cnt holds its value until the next first block.
- blk_first=1 while a message is open: abandon the old message and restart with hash_init=1. proto_err is not set.
- blk_first=1 and blk_last=1 together form a single-block message.
- proto_err is cleared only by reset.
- Reset (asynchronous, at any point including mid-round):
  - State returns to IDLE; msg_open, first_q, last_q, blk_cnt, proto_err and round counter go to 0.
  - Any in-flight block or digest is discarded.

## Timing
- Reset values: blk_ready=1 (IDLE decode, also while rst_n=0); all other outputs 0.
- Handshake in cycle N:
  - N+1: sched_load (and hash_init if first).
  - N+2..N+65: round_en with round_idx=0..63.
  - N+66: hash_update.
  - N+67: IDLE (blk_ready=1), or DONE (digest_valid=1) if last_q.
- Non-last blocks: minimum handshake-to-handshake spacing is 67 cycles.
- Last block: the next block is accepted no earlier than one cycle after the digest handshake.
- blk_valid, blk_first and blk_last are ignored outside IDLE.
- digest_ready is ignored outside DONE.
- A dropped (error) block costs one cycle; the controller is ready again at N+1.

## Test plan
- Reset, then one block with first=1, last=1:
  - sched_load and hash_init at N+1; round_idx 0..63 on N+2..N+65; hash_update at N+66; digest_valid at N+67.
  - blk_cnt=1.
- Two-block message, blocks offered back to back:
  - Second handshake at N+67 with hash_init=0; blk_cnt=2.
  - digest_valid only after the second UPDATE.
- digest_ready held low for 10 cycles in DONE:
  - digest_valid stays 1 and blk_ready stays 0.
  - Release: IDLE one cycle later.
- Block with first=0 after reset:
  - proto_err=1; no sched_load; blk_ready=1 at N+1.
  - A subsequent first=1 block processes normally and proto_err stays 1.
- rst_n pulsed low during round 30:
  - round_en=0, round_idx=0, blk_ready=1 immediately; blk_cnt=0.
  - The next first block restarts cleanly.
- CNT_W=2, five-block message:
  - blk_cnt reads 1, 2, 3, 3, 3.
  - Restart mid-message with first=1: blk_cnt=1 and hash_init=1.
